ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Pipeline stage directly downstream of the 64-bit ALU. Captures result, Z/C flags, store data,
//  destination register and control bits, and presents them to the memory stage.
//  Built as a 2-entry skid buffer with valid/ready handshake, so memory-stage back-pressure
//  never forces a combinational stall path into EX.
//  Also resolves CBZ-style branch-taken (ctl_branch & Z) at capture.
// PARAMETERS
//  n       64  datapath width (ALU result, store data)
//  REG_W   5   destination register index width
// PORTS
//  clk               in   1      rising-edge clock
//  rst               in   1      asynchronous active-high reset
//  in_valid          in   1      EX holds a valid ALU result this cycle
//  in_ready          out  1      stage can accept; registered, equals !skid_full
//  alu_result        in   n      ALU result
//  alu_z, alu_c      in   1 ea   ALU zero / carry flags
//  store_data        in   n      register B value for STUR
//  rd_addr           in   REG_W  destination register
//  ctl_mem_read      in   1      LDUR
//  ctl_mem_write     in   1      STUR
//  ctl_reg_write     in   1      writeback enable
//  ctl_mem_to_reg    in   1      writeback source select
//  ctl_branch        in   1      conditional branch on Z
//  flush             in   1      synchronous kill of all buffered entries
//  out_valid         out  1      memory-stage payload valid
//  out_ready         in   1      memory stage accepts payload
//  out_*             out  --     registered copies of every payload input above (same widths)
//  out_branch_taken  out  1      ctl_branch & alu_z, captured at accept
// BEHAVIOUR
//  - Reset, async: state EMPTY, out_valid=0, in_ready=1, all out_* payload = 0.
//  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
//  - Latency: accept in cycle t -> out_valid in t+1 when EMPTY. Throughput: 1 per cycle.
//  - States (entry count):
//    - EMPTY: accept -> ONE (loads main).
//    - ONE: accept & pop -> ONE (main reloaded); accept & !pop -> TWO (loads skid);
//      pop & !accept -> EMPTY.
//    - TWO: in_ready=0. Pop -> ONE (skid moves to main). Otherwise hold.
//  - Outputs are always driven from main; payload is stable while out_valid & !out_ready.
//  - Entries leave in FIFO order; no entry is dropped or duplicated.
//  - flush (priority over accept/pop): next state EMPTY, out_valid=0, in_ready=1.
//    Input presented in the flush cycle is discarded. Payload regs may hold stale data.
//  - Reset mid-transfer: entries are lost and all outputs return to reset values immediately.
//  - out_branch_taken is computed from input values at accept, not at pop.
//  - No arithmetic in this block; widths pass through unchanged.
// CONFIGURATION
//  - FLAGS_REG_EN defined:
//    - Adds input set_flags (1) and outputs flag_z, flag_c (1 each): architectural flag register.
//    - Flags update from alu_z/alu_c on an accept with set_flags=1.
//    - Reset value 0. Flush does not clear them; an input discarded by flush does not update them.
//  - FLAGS_REG_EN undefined: the three ports and the flag register do not exist.
// STRUCTURE
//  - arm_cpu_pkg:
//    - ex_mem_payload_t struct (result, z, c, store_data, rd_addr, ctl bits, branch_taken)
//    - skid_state_t enum {EMPTY, ONE, TWO}
//    - DATA_W=64, REG_W=5
//  - One sub-module, pipe_skid_buf: generic 2-entry valid/ready buffer over ex_mem_payload_t.
//    ex_mem_stage wraps it, adds branch resolve, and adds the optional flag register.
// TESTING
//  1. Reset then single accept (result=64'h5, rd=3, out_ready=1) -> out_valid=1 next cycle,
//     out_alu_result=5, out_rd_addr=3; in_ready stays 1.
//  2. Hold out_ready=0, push A,B -> after B in_ready=0, out=A stable.
//     Raise out_ready -> A, then B, in order; in_ready=1 the cycle after A pops.
//  3. Streaming 100 beats with out_ready=1 -> one out beat per cycle, 1-cycle latency,
//     data matches scoreboard.
//  4. TWO state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     flushed/input beats never appear.
//  5. ctl_branch=1, alu_z=1, result=0 -> out_branch_taken=1; same with alu_z=0 -> 0.
//  6. FLAGS_REG_EN: accept with set_flags=1, z=1, c=1 -> flag_z=flag_c=1;
//     accept with set_flags=0, z=0 -> flags unchanged.
//     Assert rst mid-stream -> flags 0, out_valid 0 asynchronously.

Source files
------------

// File: rtl/arm_cpu_pkg.sv
// Shared types for the EX/MEM boundary: payload struct, skid-buffer state, widths.
package arm_cpu_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } skid_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              z;
    logic              c;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd_addr;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch;
    logic              branch_taken;
  } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer over ex_mem_payload_t; in_ready and out_valid are registered.
module pipe_skid_buf
  import arm_cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  ex_mem_payload_t in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output ex_mem_payload_t out_data
);

  skid_state_t     state;
  ex_mem_payload_t skid;
  logic            accept;
  logic            pop;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // out_data is the main entry itself, so the payload holds steady under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            out_data <= in_data;
          end else if (accept) begin
            skid     <= in_data;
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            out_data <= skid;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built on a skid buffer; resolves CBZ branch-taken at capture.
// Optional architectural Z/C flag register enabled by defining FLAGS_REG_EN.
module ex_mem_stage
  import arm_cpu_pkg::*;
#(
  parameter int unsigned n     = DATA_W,
  parameter int unsigned REG_W = arm_cpu_pkg::REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     alu_result,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic [n-1:0]     store_data,
  input  logic [REG_W-1:0] rd_addr,
  input  logic             ctl_mem_read,
  input  logic             ctl_mem_write,
  input  logic             ctl_reg_write,
  input  logic             ctl_mem_to_reg,
  input  logic             ctl_branch,
  input  logic             flush,
`ifdef FLAGS_REG_EN
  input  logic             set_flags,
  output logic             flag_z,
  output logic             flag_c,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     out_alu_result,
  output logic             out_alu_z,
  output logic             out_alu_c,
  output logic [n-1:0]     out_store_data,
  output logic [REG_W-1:0] out_rd_addr,
  output logic             out_ctl_mem_read,
  output logic             out_ctl_mem_write,
  output logic             out_ctl_reg_write,
  output logic             out_ctl_mem_to_reg,
  output logic             out_ctl_branch,
  output logic             out_branch_taken
);

  ex_mem_payload_t in_data;
  ex_mem_payload_t out_data;

  always_comb begin
    in_data              = '0;
    in_data.result       = alu_result;
    in_data.z            = alu_z;
    in_data.c            = alu_c;
    in_data.store_data   = store_data;
    in_data.rd_addr      = rd_addr;
    in_data.mem_read     = ctl_mem_read;
    in_data.mem_write    = ctl_mem_write;
    in_data.reg_write    = ctl_reg_write;
    in_data.mem_to_reg   = ctl_mem_to_reg;
    in_data.branch       = ctl_branch;
    in_data.branch_taken = ctl_branch & alu_z;
  end

  pipe_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign out_alu_result     = out_data.result;
  assign out_alu_z          = out_data.z;
  assign out_alu_c          = out_data.c;
  assign out_store_data     = out_data.store_data;
  assign out_rd_addr        = out_data.rd_addr;
  assign out_ctl_mem_read   = out_data.mem_read;
  assign out_ctl_mem_write  = out_data.mem_write;
  assign out_ctl_reg_write  = out_data.reg_write;
  assign out_ctl_mem_to_reg = out_data.mem_to_reg;
  assign out_ctl_branch     = out_data.branch;
  assign out_branch_taken   = out_data.branch_taken;

`ifdef FLAGS_REG_EN
  // Flags follow accepted beats only; a beat discarded by flush leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (!flush && in_valid && in_ready && set_flags) begin
      flag_z <= alu_z;
      flag_c <= alu_c;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: queue-based reference model plus directed literal checks.
module tb_ex_mem_stage;

  typedef struct {
    logic [63:0] result;
    logic        z;
    logic        c;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
    logic        br;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] alu_result = '0;
  logic        alu_z = 1'b0;
  logic        alu_c = 1'b0;
  logic [63:0] store_data = '0;
  logic [4:0]  rd_addr = '0;
  logic        ctl_mem_read = 1'b0;
  logic        ctl_mem_write = 1'b0;
  logic        ctl_reg_write = 1'b0;
  logic        ctl_mem_to_reg = 1'b0;
  logic        ctl_branch = 1'b0;
  logic        flush = 1'b0;
  logic        set_flags = 1'b0;
  logic        flag_z;
  logic        flag_c;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_alu_result;
  logic        out_alu_z;
  logic        out_alu_c;
  logic [63:0] out_store_data;
  logic [4:0]  out_rd_addr;
  logic        out_ctl_mem_read;
  logic        out_ctl_mem_write;
  logic        out_ctl_reg_write;
  logic        out_ctl_mem_to_reg;
  logic        out_ctl_branch;
  logic        out_branch_taken;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  ex_mem_stage #(.n(64), .REG_W(5)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .alu_result         (alu_result),
    .alu_z              (alu_z),
    .alu_c              (alu_c),
    .store_data         (store_data),
    .rd_addr            (rd_addr),
    .ctl_mem_read       (ctl_mem_read),
    .ctl_mem_write      (ctl_mem_write),
    .ctl_reg_write      (ctl_reg_write),
    .ctl_mem_to_reg     (ctl_mem_to_reg),
    .ctl_branch         (ctl_branch),
    .flush              (flush),
`ifdef FLAGS_REG_EN
    .set_flags          (set_flags),
    .flag_z             (flag_z),
    .flag_c             (flag_c),
`endif
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_alu_result     (out_alu_result),
    .out_alu_z          (out_alu_z),
    .out_alu_c          (out_alu_c),
    .out_store_data     (out_store_data),
    .out_rd_addr        (out_rd_addr),
    .out_ctl_mem_read   (out_ctl_mem_read),
    .out_ctl_mem_write  (out_ctl_mem_write),
    .out_ctl_reg_write  (out_ctl_reg_write),
    .out_ctl_mem_to_reg (out_ctl_mem_to_reg),
    .out_ctl_branch     (out_ctl_branch),
    .out_branch_taken   (out_branch_taken)
  );

  always #5 clk = ~clk;

  function automatic beat_t mk(input int i);
    beat_t b;
    b.result = 64'h1000_0000_0000_0000 + 64'(i) * 64'h11;
    b.z      = i[0];
    b.c      = i[1];
    b.sd     = ~b.result;
    b.rd     = i[4:0];
    b.mr     = i[2];
    b.mw     = i[3];
    b.rw     = i[1] ^ i[0];
    b.m2r    = i[2];
    b.br     = i[0] | i[3];
    return b;
  endfunction

  function automatic beat_t cur_beat();
    beat_t b;
    b.result = alu_result;
    b.z      = alu_z;
    b.c      = alu_c;
    b.sd     = store_data;
    b.rd     = rd_addr;
    b.mr     = ctl_mem_read;
    b.mw     = ctl_mem_write;
    b.rw     = ctl_reg_write;
    b.m2r    = ctl_mem_to_reg;
    b.br     = ctl_branch;
    return b;
  endfunction

  task automatic apply(input beat_t b);
    alu_result     = b.result;
    alu_z          = b.z;
    alu_c          = b.c;
    store_data     = b.sd;
    rd_addr        = b.rd;
    ctl_mem_read   = b.mr;
    ctl_mem_write  = b.mw;
    ctl_reg_write  = b.rw;
    ctl_mem_to_reg = b.m2r;
    ctl_branch     = b.br;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO holding at most two beats, cleared by flush or reset.
  beat_t q[$];
  logic  m_fz = 1'b0;
  logic  m_fc = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit    acc;
    bit    pop;
    beat_t b;
    if (rst) begin
      q.delete();
      m_fz = 1'b0;
      m_fc = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      pop = (q.size() > 0) && out_ready;
      b   = cur_beat();
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(b);
        if (set_flags) begin
          m_fz = b.z;
          m_fc = b.c;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("out_valid", 64'(out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (q.size() != 0) begin
        check("out_alu_result", out_alu_result, q[0].result);
        check("out_alu_z", 64'(out_alu_z), 64'(q[0].z));
        check("out_alu_c", 64'(out_alu_c), 64'(q[0].c));
        check("out_store_data", out_store_data, q[0].sd);
        check("out_rd_addr", 64'(out_rd_addr), 64'(q[0].rd));
        check("out_ctl", {59'd0, out_ctl_mem_read, out_ctl_mem_write, out_ctl_reg_write,
                          out_ctl_mem_to_reg, out_ctl_branch},
              {59'd0, q[0].mr, q[0].mw, q[0].rw, q[0].m2r, q[0].br});
        check("out_branch_taken", 64'(out_branch_taken), 64'(q[0].br & q[0].z));
      end
`ifdef FLAGS_REG_EN
      check("flags_model", {62'd0, flag_z, flag_c}, {62'd0, m_fz, m_fc});
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t a;
    beat_t b;
    beat_t c;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", out_alu_result, 64'd0);
    check("rst_rd", 64'(out_rd_addr), 64'd0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // 1: single accept, one-cycle latency
    a = mk(0);
    a.result = 64'h5;
    a.rd = 5'd3;
    apply(a);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_result", out_alu_result, 64'h5);
    check("t1_rd", 64'(out_rd_addr), 64'd3);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    cyc();

    // 2: back-pressure fills both entries, then drains in order
    out_ready = 1'b0;
    a = mk(10);
    b = mk(11);
    apply(a);
    in_valid = 1'b1;
    cyc();
    apply(b);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_in_ready_full", 64'(in_ready), 64'd0);
    check("t2_hold_a", out_alu_result, 64'h1000_0000_0000_00AA);
    cyc();
    @(negedge clk);
    check("t2_still_a", out_alu_result, 64'h1000_0000_0000_00AA);
    out_ready = 1'b1;
    cyc();
    @(negedge clk);
    check("t2_then_b", out_alu_result, 64'h1000_0000_0000_00BB);
    check("t2_ready_back", 64'(in_ready), 64'd1);
    check("t2_valid_b", 64'(out_valid), 64'd1);
    cyc();
    @(negedge clk);
    check("t2_drained", 64'(out_valid), 64'd0);

    // 3: streaming at full rate
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = mk(100 + i);
      apply(a);
      @(posedge clk);
      @(negedge clk);
      check("t3_stream", out_alu_result, a.result);
    end
    in_valid = 1'b0;
    cyc();
    cyc();

    // Mixed stall pattern, checked by the model only
    for (int i = 0; i < 40; i++) begin
      apply(mk(300 + i));
      in_valid = (i % 4) != 3;
      out_ready = (i % 3) != 0;
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();

    // 4: flush from full with a beat presented
    out_ready = 1'b0;
    in_valid = 1'b1;
    apply(mk(20));
    cyc();
    apply(mk(21));
    cyc();
    c = mk(22);
    apply(c);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_flush_valid", 64'(out_valid), 64'd0);
    check("t4_flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    check("t4_nothing_out", 64'(out_valid), 64'd0);

    // 5: branch resolved at capture
    a = mk(0);
    a.result = '0;
    a.br = 1'b1;
    a.z = 1'b1;
    apply(a);
    in_valid = 1'b1;
    cyc();
    a.z = 1'b0;
    apply(a);
    @(negedge clk);
    check("t5_taken", 64'(out_branch_taken), 64'd1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_not_taken", 64'(out_branch_taken), 64'd0);
    cyc();

`ifdef FLAGS_REG_EN
    // 6: flag register
    a = mk(0);
    a.z = 1'b1;
    a.c = 1'b1;
    apply(a);
    set_flags = 1'b1;
    in_valid = 1'b1;
    cyc();
    @(negedge clk);
    check("t6_flags_set", {62'd0, flag_z, flag_c}, 64'd3);
    a.z = 1'b0;
    a.c = 1'b0;
    apply(a);
    set_flags = 1'b0;
    cyc();
    @(negedge clk);
    check("t6_flags_keep", {62'd0, flag_z, flag_c}, 64'd3);
    set_flags = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    set_flags = 1'b0;
    @(negedge clk);
    check("t6_flags_flush", {62'd0, flag_z, flag_c}, 64'd3);
`endif

    // Asynchronous reset in the middle of a transfer
    out_ready = 1'b0;
    in_valid = 1'b1;
    apply(mk(7));
    cyc();
    apply(mk(9));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    check("rst_mid_result", out_alu_result, 64'd0);
    check("rst_mid_bt", 64'(out_branch_taken), 64'd0);
`ifdef FLAGS_REG_EN
    check("rst_mid_flags", {62'd0, flag_z, flag_c}, 64'd0);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    check("post_rst_empty", 64'(out_valid), 64'd0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
